// File: rtl/soe_error_accumulator_if.sv
// Bus bundle for soe_error_accumulator: run control, the compared vector stream,
// run status and the counter readout port.
//   master : harness/host side (drives start/abort/max_cycles, vectors, rd_req/rd_idx)
//   slave  : accumulator side (drives busy/done/cycle_cnt, rd_ack/rd_data)
interface soe_error_accumulator_if #(
    parameter int unsigned NUM_OUT = 7,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned CYC_W   = 32
);
    localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    logic               start;
    logic               abort;
    logic [CYC_W-1:0]   max_cycles;
    logic               out_valid;
    logic [NUM_OUT-1:0] out_dut;
    logic [NUM_OUT-1:0] out_golden;
    logic               busy;
    logic               done;
    logic [CYC_W-1:0]   cycle_cnt;
    logic               rd_req;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_ack;
    logic [CNT_W-1:0]   rd_data;

    modport master (
        output start, abort, max_cycles, out_valid, out_dut, out_golden, rd_req, rd_idx,
        input  busy, done, cycle_cnt, rd_ack, rd_data
    );

    modport slave (
        input  start, abort, max_cycles, out_valid, out_dut, out_golden, rd_req, rd_idx,
        output busy, done, cycle_cnt, rd_ack, rd_data
    );
endinterface

// File: rtl/soe_error_accumulator.sv
// Result end of the fault-emulation harness: compares DUT against golden outputs on
// every valid vector of a run and keeps a saturating mismatch (SoE) counter per output
// bit, then holds the counters for host readout.
// Ports:
//   clk    - single clock, posedge
//   rst_n  - synchronous active-low reset
//   bus    - slave side of soe_error_accumulator_if (control, vectors, status, readout)
module soe_error_accumulator #(
    parameter int unsigned NUM_OUT = 7,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned CYC_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    soe_error_accumulator_if.slave bus
);
    localparam int unsigned      IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               clear_c;
    logic               count_c;
    logic [CYC_W-1:0]   max_q;
    logic [CYC_W-1:0]   cycle_q;
    logic [CYC_W-1:0]   cycle_inc_c;
    logic [NUM_OUT-1:0] miss_c;
    logic [CNT_W-1:0]   soe_q [NUM_OUT];
    logic [CNT_W-1:0]   rd_sel_c;
    logic               busy_q;
    logic               done_q;
    logic               rd_ack_q;
    logic [CNT_W-1:0]   rd_data_q;

    assign cycle_inc_c = cycle_q + CYC_W'(1);
    assign miss_c      = bus.out_dut ^ bus.out_golden;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        count_c = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    clear_c = 1'b1;
                    state_d = (bus.max_cycles == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.out_valid) begin
                    count_c = 1'b1;
                    // The vector that reaches the limit is itself counted.
                    if (cycle_inc_c == max_q) begin
                        state_d = ST_DONE;
                    end
                end
                if (bus.abort) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Run limit, vector counter and per-bit saturating SoE counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q   <= '0;
            cycle_q <= '0;
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                soe_q[i] <= '0;
            end
        end else if (clear_c) begin
            max_q   <= bus.max_cycles;
            cycle_q <= '0;
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                soe_q[i] <= '0;
            end
        end else if (count_c) begin
            cycle_q <= cycle_inc_c;
            for (int i = 0; i < int'(NUM_OUT); i++) begin
                if (miss_c[i] && (soe_q[i] != CNT_MAX)) begin
                    soe_q[i] <= soe_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Status flags decode the registered state, so they trail it by one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_q == ST_RUN);
            done_q <= (state_q == ST_DONE);
        end
    end

    // Readout select; indices past the last counter read as zero
    always_comb begin
        rd_sel_c = '0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            if (bus.rd_idx == IDX_W'(i)) begin
                rd_sel_c = soe_q[i];
            end
        end
    end

    // Readout register: returns the pre-increment value, holds when idle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= bus.rd_req;
            if (bus.rd_req) begin
                rd_data_q <= rd_sel_c;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cycle_cnt = cycle_q;
    assign bus.rd_ack    = rd_ack_q;
    assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_soe_error_accumulator.sv
// Self-checking bench for soe_error_accumulator: directed scenarios plus randomized runs
// checked against a transaction-level model of the SoE counts.
module tb_soe_error_accumulator;
    localparam int unsigned NO  = 7;
    localparam int unsigned CW  = 32;
    localparam int unsigned YW  = 32;
    localparam int unsigned SCW = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    int   exp_soe [NO];

    soe_error_accumulator_if #(.NUM_OUT(NO), .CNT_W(CW),  .CYC_W(YW)) bif ();
    soe_error_accumulator_if #(.NUM_OUT(NO), .CNT_W(SCW), .CYC_W(YW)) sif ();

    soe_error_accumulator #(.NUM_OUT(NO), .CNT_W(CW), .CYC_W(YW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    soe_error_accumulator #(.NUM_OUT(NO), .CNT_W(SCW), .CYC_W(YW)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.start = 0; bif.abort = 0; bif.max_cycles = '0; bif.out_valid = 0;
        bif.out_dut = '0; bif.out_golden = '0; bif.rd_req = 0; bif.rd_idx = '0;
        sif.start = 0; sif.abort = 0; sif.max_cycles = '0; sif.out_valid = 0;
        sif.out_dut = '0; sif.out_golden = '0; sif.rd_req = 0; sif.rd_idx = '0;
    endtask

    task automatic start_run(input int max);
        bif.start = 1; bif.max_cycles = YW'(max);
        tick();
        bif.start = 0;
        for (int i = 0; i < int'(NO); i++) exp_soe[i] = 0;
    endtask

    task automatic vec(input logic v, input logic [NO-1:0] d, input logic [NO-1:0] g, input logic ab);
        bif.out_valid = v; bif.out_dut = d; bif.out_golden = g; bif.abort = ab;
        tick();
        bif.out_valid = 0; bif.abort = 0;
    endtask

    task automatic read_one(input int idx, output logic [CW-1:0] data, output logic ack);
        bif.rd_req = 1; bif.rd_idx = 3'(idx);
        tick();
        bif.rd_req = 0;
        data = bif.rd_data; ack = bif.rd_ack;
    endtask

    task automatic read_sat(input int idx, output logic [SCW-1:0] data);
        sif.rd_req = 1; sif.rd_idx = 3'(idx);
        tick();
        sif.rd_req = 0;
        data = sif.rd_data;
    endtask

    // Reads all counters and compares against exp_soe
    task automatic check_counters(input string tag);
        logic [CW-1:0] d;
        logic          a;
        for (int i = 0; i < int'(NO); i++) begin
            read_one(i, d, a);
            n_cmp++;
            if (a !== 1'b1 || d !== CW'(exp_soe[i])) begin
                n_bad++;
                $display("FAIL %s soe[%0d]: got %0d ack=%b, expected %0d ack=1", tag, i, d, a, exp_soe[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        bif.start = 1; bif.max_cycles = YW'(5); bif.rd_req = 1;
        repeat (3) tick();
        n_cmp++;
        if (bif.busy !== 0 || bif.done !== 0 || bif.rd_ack !== 0 || bif.rd_data !== '0 || bif.cycle_cnt !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%b done=%b ack=%b data=%0d cyc=%0d, expected all 0",
                     bif.busy, bif.done, bif.rd_ack, bif.rd_data, bif.cycle_cnt);
        end
        rst_n = 1; bif.start = 0; bif.rd_req = 0;
        tick();
        for (int i = 0; i < int'(NO); i++) exp_soe[i] = 0;
        check_counters("reset");
        n_cmp++;
        if (bif.busy !== 0 || bif.done !== 0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b done=%b, expected 0 0", bif.busy, bif.done);
        end
    endtask

    task automatic test_basic();
        logic [NO-1:0] dv [4];
        dv[0] = 7'h01; dv[1] = 7'h00; dv[2] = 7'h41; dv[3] = 7'h01;
        start_run(4);
        for (int k = 0; k < 4; k++) vec(1'b1, dv[k], 7'h00, 1'b0);
        exp_soe[0] = 3; exp_soe[6] = 1;
        vec(1'b1, 7'h7f, 7'h00, 1'b0);
        tick();
        n_cmp++;
        if (bif.done !== 1 || bif.busy !== 0 || bif.cycle_cnt !== YW'(4)) begin
            n_bad++;
            $display("FAIL basic_status: done=%b busy=%b cyc=%0d, expected 1 0 4", bif.done, bif.busy, bif.cycle_cnt);
        end
        check_counters("basic");
    endtask

    task automatic test_gaps();
        logic          pat [5];
        logic [NO-1:0] d;
        logic [NO-1:0] g;
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
        start_run(3);
        for (int k = 0; k < 5; k++) begin
            d = NO'($urandom); g = NO'($urandom);
            vec(pat[k], d, g, 1'b0);
            if (pat[k]) for (int i = 0; i < int'(NO); i++) exp_soe[i] += int'(d[i] != g[i]);
        end
        // Vectors after the limit must be ignored
        vec(1'b1, 7'h7f, 7'h00, 1'b0);
        vec(1'b1, 7'h7f, 7'h00, 1'b0);
        n_cmp++;
        if (bif.done !== 1 || bif.cycle_cnt !== YW'(3)) begin
            n_bad++;
            $display("FAIL gaps_status: done=%b cyc=%0d, expected 1 3", bif.done, bif.cycle_cnt);
        end
        check_counters("gaps");
        start_run(0);
        vec(1'b1, 7'h7f, 7'h00, 1'b0);
        tick();
        n_cmp++;
        if (bif.done !== 1 || bif.busy !== 0 || bif.cycle_cnt !== '0) begin
            n_bad++;
            $display("FAIL max0_status: done=%b busy=%b cyc=%0d, expected 1 0 0", bif.done, bif.busy, bif.cycle_cnt);
        end
        check_counters("max0");
    endtask

    task automatic test_abort();
        logic [NO-1:0] d;
        logic [NO-1:0] g;
        start_run(100);
        for (int k = 1; k <= 10; k++) begin
            d = NO'($urandom); g = NO'($urandom);
            if (k == 10) d = g ^ 7'h24;
            vec(1'b1, d, g, (k == 10));
            for (int i = 0; i < int'(NO); i++) exp_soe[i] += int'(d[i] != g[i]);
        end
        vec(1'b1, 7'h7f, 7'h00, 1'b0);
        n_cmp++;
        if (bif.done !== 1 || bif.cycle_cnt !== YW'(10)) begin
            n_bad++;
            $display("FAIL abort_status: done=%b cyc=%0d, expected 1 10", bif.done, bif.cycle_cnt);
        end
        check_counters("abort");
        start_run(5);
        tick();
        n_cmp++;
        if (bif.busy !== 1 || bif.done !== 0 || bif.cycle_cnt !== '0) begin
            n_bad++;
            $display("FAIL restart_status: busy=%b done=%b cyc=%0d, expected 1 0 0", bif.busy, bif.done, bif.cycle_cnt);
        end
        check_counters("restart");
        bif.abort = 1; tick(); bif.abort = 0;
    endtask

    task automatic test_saturation();
        logic [SCW-1:0] d;
        sif.start = 1; sif.max_cycles = YW'(20);
        tick();
        sif.start = 0;
        for (int k = 0; k < 20; k++) begin
            sif.out_valid = 1; sif.out_golden = 7'h00;
            sif.out_dut = (k < 10) ? 7'h05 : 7'h04;
            tick();
        end
        sif.out_valid = 0;
        tick();
        n_cmp++;
        if (sif.done !== 1 || sif.cycle_cnt !== YW'(20)) begin
            n_bad++;
            $display("FAIL sat_status: done=%b cyc=%0d, expected 1 20", sif.done, sif.cycle_cnt);
        end
        for (int i = 0; i < int'(NO); i++) begin
            read_sat(i, d);
            n_cmp++;
            if (d !== SCW'((i == 2) ? 15 : (i == 0) ? 10 : 0)) begin
                n_bad++;
                $display("FAIL sat soe[%0d]: got %0d, expected %0d", i, d, (i == 2) ? 15 : (i == 0) ? 10 : 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        int            idx [3];
        logic [CW-1:0] d;
        start_run(3);
        vec(1'b1, 7'h03, 7'h00, 1'b0);
        vec(1'b1, 7'h02, 7'h00, 1'b0);
        vec(1'b1, 7'h7e, 7'h7f, 1'b0);
        exp_soe[0] = 2; exp_soe[1] = 2;
        idx[0] = 0; idx[1] = 1; idx[2] = 7;
        bif.rd_req = 1;
        for (int k = 0; k < 3; k++) begin
            bif.rd_idx = 3'(idx[k]);
            tick();
            n_cmp++;
            d = (idx[k] < int'(NO)) ? CW'(exp_soe[idx[k]]) : '0;
            if (bif.rd_ack !== 1 || bif.rd_data !== d) begin
                n_bad++;
                $display("FAIL b2b_read%0d: ack=%b data=%0d, expected ack=1 data=%0d", k, bif.rd_ack, bif.rd_data, d);
            end
        end
        bif.rd_req = 0; bif.rd_idx = 3'd0;
        tick();
        n_cmp++;
        if (bif.rd_ack !== 0 || bif.rd_data !== '0) begin
            n_bad++;
            $display("FAIL b2b_hold: ack=%b data=%0d, expected ack=0 data=0", bif.rd_ack, bif.rd_data);
        end
    endtask

    task automatic test_readout_in_run();
        logic [CW-1:0] d;
        logic          a;
        start_run(50);
        for (int k = 0; k < 3; k++) begin
            bif.out_valid = 1; bif.out_dut = 7'h01; bif.out_golden = 7'h00;
            read_one(0, d, a);
            bif.out_valid = 0;
            n_cmp++;
            if (a !== 1 || d !== CW'(k)) begin
                n_bad++;
                $display("FAIL run_read%0d: ack=%b data=%0d, expected ack=1 data=%0d", k, a, d, k);
            end
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        tick(); tick();
        n_cmp++;
        if (bif.busy !== 0 || bif.done !== 0 || bif.cycle_cnt !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset: busy=%b done=%b cyc=%0d, expected 0 0 0", bif.busy, bif.done, bif.cycle_cnt);
        end
        for (int i = 0; i < int'(NO); i++) exp_soe[i] = 0;
        check_counters("midrun_reset");
    endtask

    task automatic test_random();
        int            max;
        int            cnt;
        int            guard;
        bit            running;
        logic          v;
        logic          ab;
        logic [NO-1:0] d;
        logic [NO-1:0] g;
        for (int r = 0; r < 8; r++) begin
            max = int'($urandom_range(1, 40));
            start_run(max);
            cnt = 0; running = 1; guard = 0;
            while (running && guard < 1000) begin
                v  = ($urandom_range(0, 3) != 0);
                ab = (r % 2 == 1) && ($urandom_range(0, 29) == 0);
                d  = NO'($urandom); g = NO'($urandom);
                vec(v, d, g, ab);
                if (v) begin
                    cnt++;
                    for (int i = 0; i < int'(NO); i++) exp_soe[i] += int'(d[i] != g[i]);
                end
                if (cnt == max || ab) running = 0;
                guard++;
            end
            for (int k = 0; k < 3; k++) vec(1'b1, NO'($urandom), NO'($urandom), 1'b0);
            n_cmp++;
            if (bif.done !== 1 || bif.busy !== 0 || bif.cycle_cnt !== YW'(cnt)) begin
                n_bad++;
                $display("FAIL rand%0d_status: done=%b busy=%b cyc=%0d, expected 1 0 %0d",
                         r, bif.done, bif.busy, bif.cycle_cnt, cnt);
            end
            check_counters($sformatf("rand%0d", r));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 0;
        idle_inputs();
        tick();
        test_reset();
        test_basic();
        test_gaps();
        test_abort();
        test_saturation();
        test_back_to_back();
        test_readout_in_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
